axi_arbiter_2x1: RTL and testbench

Transaction-level arbiter that shares the single AXI master port (the `wrap_*` side toward the AXI wrapper) between two independent masters, e.g. the D-cache refill/writeback port and the uncached/config port, so both can be active without a software-controlled select. Read and write channels are arbitrated independently with 2-way round-robin. A grant is held for a whole burst: address handshake through last data beat on reads, and through the B response on writes.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/axi_arbiter_2x1_if.sv | 47 ++++
 rtl/rr_arb2.sv | 16 +
 rtl/axi_arbiter_2x1.sv | 128 ++++++++++++
 tb/tb_axi_arbiter_2x1.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_arb_pkg.sv
// Shared constants for the two-master AXI arbiter: default bus widths and
// the read/write channel state encodings.
package axi_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] rd_state_t;
    typedef logic [1:0] wr_state_t;

    localparam rd_state_t RD_IDLE = 2'd0;
    localparam rd_state_t RD_ADDR = 2'd1;
    localparam rd_state_t RD_DATA = 2'd2;

    localparam wr_state_t WR_IDLE = 2'd0;
    localparam wr_state_t WR_ADDR = 2'd1;
    localparam wr_state_t WR_DATA = 2'd2;
    localparam wr_state_t WR_RESP = 2'd3;

endpackage

// File: rtl/axi_arbiter_2x1_if.sv
// One AXI master-to-slave link (AR/R/AW/W/B without id or resp fields).
// The master modport is the side that issues requests.
interface axi_arbiter_2x1_if
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arlen, arsize, arvalid, input arready,
        input rdata, rlast, rvalid, output rready,
        output awaddr, awlen, awsize, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bvalid, output bready
    );

    modport slave (
        input araddr, arlen, arsize, arvalid, output arready,
        output rdata, rlast, rvalid, input rready,
        input awaddr, awlen, awsize, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bvalid, input bready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the master not granted last time wins.
// last_nxt only moves when en says the grant is actually being taken.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic       gnt,
    output logic       last_nxt
);

    always_comb begin
        gnt      = (req == 2'b11) ? ~last : req[1];
        last_nxt = en ? gnt : last;
    end

endmodule

// File: rtl/axi_arbiter_2x1.sv
// Shares one AXI master port between two masters. Read and write channels
// arbitrate independently and hold their grant for a whole burst.
module axi_arbiter_2x1
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    axi_arbiter_2x1_if.slave   m0,
    axi_arbiter_2x1_if.slave   m1,
    axi_arbiter_2x1_if.master  s
);

    rd_state_t rd_state;
    wr_state_t wr_state;
    logic      rd_gnt, rd_last, rd_pick, rd_last_nxt, rd_take;
    logic      wr_gnt, wr_last, wr_pick, wr_last_nxt, wr_take;

    assign rd_take = (rd_state == RD_IDLE) && (m0.arvalid || m1.arvalid);
    assign wr_take = (wr_state == WR_IDLE) && (m0.awvalid || m1.awvalid);

    rr_arb2 u_rd_arb (
        .req      ({m1.arvalid, m0.arvalid}),
        .last     (rd_last),
        .en       (rd_take),
        .gnt      (rd_pick),
        .last_nxt (rd_last_nxt)
    );

    rr_arb2 u_wr_arb (
        .req      ({m1.awvalid, m0.awvalid}),
        .last     (wr_last),
        .en       (wr_take),
        .gnt      (wr_pick),
        .last_nxt (wr_last_nxt)
    );

    // last = 1 out of reset so master 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rd_gnt   <= 1'b0;
            rd_last  <= 1'b1;
        end else begin
            case (rd_state)
                RD_IDLE: if (rd_take) begin
                    rd_gnt   <= rd_pick;
                    rd_last  <= rd_last_nxt;
                    rd_state <= RD_ADDR;
                end
                RD_ADDR: if (s.arvalid && s.arready) rd_state <= RD_DATA;
                RD_DATA: if (s.rvalid && s.rready && s.rlast) rd_state <= RD_IDLE;
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            wr_gnt   <= 1'b0;
            wr_last  <= 1'b1;
        end else begin
            case (wr_state)
                WR_IDLE: if (wr_take) begin
                    wr_gnt   <= wr_pick;
                    wr_last  <= wr_last_nxt;
                    wr_state <= WR_ADDR;
                end
                WR_ADDR: if (s.awvalid && s.awready) wr_state <= WR_DATA;
                WR_DATA: if (s.wvalid && s.wready && s.wlast) wr_state <= WR_RESP;
                WR_RESP: if (s.bvalid && s.bready) wr_state <= WR_IDLE;
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    logic                ar_ph, r_ph, aw_ph, w_ph, b_ph;
    logic [ADDR_W-1:0]   ar_addr_sel, aw_addr_sel;
    logic [DATA_W-1:0]   w_data_sel;
    logic [DATA_W/8-1:0] w_strb_sel;

    assign ar_ph = (rd_state == RD_ADDR);
    assign r_ph  = (rd_state == RD_DATA);
    assign aw_ph = (wr_state == WR_ADDR);
    assign w_ph  = (wr_state == WR_DATA);
    assign b_ph  = (wr_state == WR_RESP);

    assign ar_addr_sel = rd_gnt ? m1.araddr : m0.araddr;
    assign aw_addr_sel = wr_gnt ? m1.awaddr : m0.awaddr;
    assign w_data_sel  = wr_gnt ? m1.wdata  : m0.wdata;
    assign w_strb_sel  = wr_gnt ? m1.wstrb  : m0.wstrb;

    // Slave-side requests: payload is zeroed outside the owning phase
    assign s.araddr  = ar_ph ? ar_addr_sel : '0;
    assign s.arlen   = ar_ph ? (rd_gnt ? m1.arlen  : m0.arlen)  : '0;
    assign s.arsize  = ar_ph ? (rd_gnt ? m1.arsize : m0.arsize) : '0;
    assign s.arvalid = ar_ph & (rd_gnt ? m1.arvalid : m0.arvalid);
    assign s.rready  = r_ph  & (rd_gnt ? m1.rready  : m0.rready);
    assign s.awaddr  = aw_ph ? aw_addr_sel : '0;
    assign s.awlen   = aw_ph ? (wr_gnt ? m1.awlen  : m0.awlen)  : '0;
    assign s.awsize  = aw_ph ? (wr_gnt ? m1.awsize : m0.awsize) : '0;
    assign s.awvalid = aw_ph & (wr_gnt ? m1.awvalid : m0.awvalid);
    assign s.wdata   = w_ph ? w_data_sel : '0;
    assign s.wstrb   = w_ph ? w_strb_sel : '0;
    assign s.wlast   = w_ph & (wr_gnt ? m1.wlast  : m0.wlast);
    assign s.wvalid  = w_ph & (wr_gnt ? m1.wvalid : m0.wvalid);
    assign s.bready  = b_ph & (wr_gnt ? m1.bready : m0.bready);

    // Master-side responses reach only the granted master
    assign m0.arready = ar_ph & ~rd_gnt & s.arready;
    assign m1.arready = ar_ph &  rd_gnt & s.arready;
    assign m0.rvalid  = r_ph  & ~rd_gnt & s.rvalid;
    assign m1.rvalid  = r_ph  &  rd_gnt & s.rvalid;
    assign m0.rlast   = r_ph  & ~rd_gnt & s.rlast;
    assign m1.rlast   = r_ph  &  rd_gnt & s.rlast;
    assign m0.rdata   = (r_ph && !rd_gnt) ? s.rdata : '0;
    assign m1.rdata   = (r_ph &&  rd_gnt) ? s.rdata : '0;
    assign m0.awready = aw_ph & ~wr_gnt & s.awready;
    assign m1.awready = aw_ph &  wr_gnt & s.awready;
    assign m0.wready  = w_ph  & ~wr_gnt & s.wready;
    assign m1.wready  = w_ph  &  wr_gnt & s.wready;
    assign m0.bvalid  = b_ph  & ~wr_gnt & s.bvalid;
    assign m1.bvalid  = b_ph  &  wr_gnt & s.bvalid;

endmodule

// File: tb/tb_axi_arbiter_2x1.sv
// Directed bench for axi_arbiter_2x1: arbitration, burst hold, routing,
// early W stall and mid-burst reset, all with hand-computed expectations.
module tb_axi_arbiter_2x1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    axi_arbiter_2x1_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    axi_arbiter_2x1_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    axi_arbiter_2x1_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

    axi_arbiter_2x1 #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_if),
        .m1  (m1_if),
        .s   (s_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clr_inputs();
        m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0; m0_if.arvalid = 0; m0_if.rready = 0;
        m0_if.awaddr = '0; m0_if.awlen = '0; m0_if.awsize = '0; m0_if.awvalid = 0;
        m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wlast = 0; m0_if.wvalid = 0; m0_if.bready = 0;
        m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0; m1_if.arvalid = 0; m1_if.rready = 0;
        m1_if.awaddr = '0; m1_if.awlen = '0; m1_if.awsize = '0; m1_if.awvalid = 0;
        m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wlast = 0; m1_if.wvalid = 0; m1_if.bready = 0;
        s_if.arready = 0; s_if.rdata = '0; s_if.rlast = 0; s_if.rvalid = 0;
        s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0;
    endtask

    // n read beats to master `who`; ends in the following IDLE cycle
    task automatic rd_data(input int who, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (who == 0) m0_if.arvalid = 0; else m1_if.arvalid = 0;
            end
            s_if.rvalid = 1; s_if.rdata = base + i; s_if.rlast = (i == n - 1);
            m0_if.rready = 1; m1_if.rready = 1;
            #1;
            chk("rd_gnt_rvalid", (who == 0) ? m0_if.rvalid : m1_if.rvalid, 1);
            chk("rd_gnt_rdata", (who == 0) ? m0_if.rdata : m1_if.rdata, base + i);
            chk("rd_other_rvalid", (who == 0) ? m1_if.rvalid : m0_if.rvalid, 0);
            chk("rd_s_rready", s_if.rready, 1);
        end
        @(negedge clk);
        s_if.rvalid = 0; s_if.rlast = 0;
        #1 chk("rd_idle_arvalid", s_if.arvalid, 0);
    endtask

    // One single-beat write burst granted to `who`, starting from IDLE
    task automatic wr_burst(input int who);
        logic [31:0] ea, ed;
        ea = (who == 0) ? 32'h0000_6000 : 32'h0000_7000;
        ed = (who == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1;
        @(negedge clk); #1;
        chk("wb_awvalid", s_if.awvalid, 1);
        chk("wb_awaddr", s_if.awaddr, ea);
        chk("wb_gnt_awready", (who == 0) ? m0_if.awready : m1_if.awready, 1);
        chk("wb_oth_awready", (who == 0) ? m1_if.awready : m0_if.awready, 0);
        @(negedge clk); #1;
        chk("wb_wvalid", s_if.wvalid, 1);
        chk("wb_wdata", s_if.wdata, ed);
        chk("wb_oth_wready", (who == 0) ? m1_if.wready : m0_if.wready, 0);
        @(negedge clk); #1;
        chk("wb_hold_bvalid", (who == 0) ? m0_if.bvalid : m1_if.bvalid, 0);
        chk("wb_hold_awvalid", s_if.awvalid, 0);
        chk("wb_bready", s_if.bready, 1);
        @(negedge clk);
        s_if.bvalid = 1;
        #1;
        chk("wb_gnt_bvalid", (who == 0) ? m0_if.bvalid : m1_if.bvalid, 1);
        chk("wb_oth_bvalid", (who == 0) ? m1_if.bvalid : m0_if.bvalid, 0);
        @(negedge clk);
        s_if.bvalid = 0;
        #1 chk("wb_idle_awvalid", s_if.awvalid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        clk = 0; rst = 1;
        clr_inputs();
        s_if.rvalid = 1; s_if.rdata = 32'hFFFF_FFFF; s_if.bvalid = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_arvalid", s_if.arvalid, 0);
        chk("rst_s_awvalid", s_if.awvalid, 0);
        chk("rst_s_rready", s_if.rready, 0);
        chk("rst_s_bready", s_if.bready, 0);
        chk("rst_m0_rvalid", m0_if.rvalid, 0);
        chk("rst_m0_rdata", m0_if.rdata, 0);
        chk("rst_m1_bvalid", m1_if.bvalid, 0);
        chk("rst_s_araddr", s_if.araddr, 0);
        @(negedge clk);
        rst = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.bvalid = 0;

        // Read tie after reset: m0 first, then m1
        @(negedge clk);
        m0_if.araddr = 32'h1000; m0_if.arlen = 4'd3; m0_if.arsize = 3'd2; m0_if.arvalid = 1;
        m1_if.araddr = 32'h2000; m1_if.arlen = 4'd3; m1_if.arsize = 3'd2; m1_if.arvalid = 1;
        s_if.arready = 1;
        #1 chk("t1_idle_arvalid", s_if.arvalid, 0);
        @(negedge clk); #1;
        chk("t1_araddr_m0", s_if.araddr, 32'h1000);
        chk("t1_arlen", s_if.arlen, 3);
        chk("t1_m0_arready", m0_if.arready, 1);
        chk("t1_m1_arready", m1_if.arready, 0);
        rd_data(0, 4, 32'hA000);
        @(negedge clk); #1;
        chk("t1_araddr_m1", s_if.araddr, 32'h2000);
        chk("t1_m1_arready2", m1_if.arready, 1);
        chk("t1_m0_arready2", m0_if.arready, 0);
        rd_data(1, 4, 32'hB000);

        // m1 write concurrent with m0 read
        @(negedge clk);
        m0_if.araddr = 32'h3000; m0_if.arlen = 4'd7; m0_if.arvalid = 1;
        m1_if.awaddr = 32'h1FC0_0010; m1_if.awlen = 4'd0; m1_if.awsize = 3'd2; m1_if.awvalid = 1;
        m1_if.wdata = 32'hDEAD_BEEF; m1_if.wstrb = 4'hF; m1_if.wlast = 1; m1_if.wvalid = 1;
        s_if.awready = 1; s_if.wready = 1;
        #1 chk("t2_idle_awvalid", s_if.awvalid, 0);
        @(negedge clk); #1;
        chk("t2_awaddr", s_if.awaddr, 32'h1FC0_0010);
        chk("t2_araddr", s_if.araddr, 32'h3000);
        chk("t2_awvalid", s_if.awvalid, 1);
        chk("t2_arvalid", s_if.arvalid, 1);
        chk("t2_m1_awready", m1_if.awready, 1);
        chk("t2_m1_wready_stall", m1_if.wready, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin m0_if.arvalid = 0; m1_if.awvalid = 0; end
            if (i == 1) begin m1_if.wvalid = 0; m1_if.wlast = 0; s_if.bvalid = 1; m1_if.bready = 1; end
            if (i == 2) begin s_if.bvalid = 0; m1_if.bready = 0; end
            s_if.rvalid = 1; s_if.rdata = 32'hC000 + i; s_if.rlast = (i == 7); m0_if.rready = 1;
            #1;
            chk("t2_m0_rdata", m0_if.rdata, 32'hC000 + i);
            chk("t2_m1_rvalid", m1_if.rvalid, 0);
            if (i == 0) begin
                chk("t2_wdata", s_if.wdata, 32'hDEAD_BEEF);
                chk("t2_wstrb", s_if.wstrb, 4'hF);
                chk("t2_wlast", s_if.wlast, 1);
                chk("t2_m1_wready", m1_if.wready, 1);
            end
            if (i == 1) begin
                chk("t2_m1_bvalid", m1_if.bvalid, 1);
                chk("t2_s_bready", s_if.bready, 1);
                chk("t2_m0_bvalid", m0_if.bvalid, 0);
                chk("t2_resp_wvalid", s_if.wvalid, 0);
            end
            if (i == 2) begin
                chk("t2_wr_idle_awvalid", s_if.awvalid, 0);
                chk("t2_wr_idle_bvalid", m1_if.bvalid, 0);
            end
        end
        @(negedge clk);
        s_if.rvalid = 0; s_if.rlast = 0;
        #1 chk("t2_rd_idle_arvalid", s_if.arvalid, 0);

        // arready stalled: m1 (not granted last) holds the grant
        @(negedge clk);
        m0_if.araddr = 32'h4000; m0_if.arlen = 4'd0; m0_if.arvalid = 1;
        m1_if.araddr = 32'h5000; m1_if.arlen = 4'd0; m1_if.arvalid = 1;
        s_if.arready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("t3_hold_arvalid", s_if.arvalid, 1);
            chk("t3_hold_araddr", s_if.araddr, 32'h5000);
            chk("t3_hold_m1_arready", m1_if.arready, 0);
            chk("t3_hold_m0_arready", m0_if.arready, 0);
        end
        @(negedge clk);
        s_if.arready = 1;
        #1;
        chk("t3_m1_arready", m1_if.arready, 1);
        chk("t3_araddr", s_if.araddr, 32'h5000);
        rd_data(1, 1, 32'hD000);
        @(negedge clk); #1;
        chk("t3_araddr_m0", s_if.araddr, 32'h4000);
        chk("t3_m0_arready", m0_if.arready, 1);
        rd_data(0, 1, 32'hE000);

        // Six write bursts with both masters always requesting
        @(negedge clk);
        m0_if.awaddr = 32'h6000; m0_if.awlen = 4'd0; m0_if.awvalid = 1;
        m0_if.wdata = 32'hA0A0_A0A0; m0_if.wstrb = 4'hF; m0_if.wlast = 1; m0_if.wvalid = 1; m0_if.bready = 1;
        m1_if.awaddr = 32'h7000; m1_if.awlen = 4'd0; m1_if.awvalid = 1;
        m1_if.wdata = 32'hB1B1_B1B1; m1_if.wstrb = 4'hF; m1_if.wlast = 1; m1_if.wvalid = 1; m1_if.bready = 1;
        for (int k = 0; k < 6; k++) wr_burst(k % 2);
        m0_if.awvalid = 0; m0_if.wvalid = 0; m0_if.wlast = 0; m0_if.bready = 0;
        m1_if.awvalid = 0; m1_if.wvalid = 0; m1_if.wlast = 0; m1_if.bready = 0;

        // W issued two cycles ahead of AW is stalled
        @(negedge clk);
        m0_if.wdata = 32'h1234_5678; m0_if.wstrb = 4'hF; m0_if.wlast = 0; m0_if.wvalid = 1;
        #1 chk("t5_early_wready0", m0_if.wready, 0);
        @(negedge clk);
        #1 chk("t5_early_wready1", m0_if.wready, 0);
        @(negedge clk);
        m0_if.awaddr = 32'h8000; m0_if.awlen = 4'd1; m0_if.awvalid = 1;
        #1;
        chk("t5_idle_wready", m0_if.wready, 0);
        chk("t5_idle_wvalid", s_if.wvalid, 0);
        @(negedge clk); #1;
        chk("t5_awready", m0_if.awready, 1);
        chk("t5_addr_wready", m0_if.wready, 0);
        @(negedge clk);
        m0_if.awvalid = 0;
        #1;
        chk("t5_beat0_wready", m0_if.wready, 1);
        chk("t5_beat0_wdata", s_if.wdata, 32'h1234_5678);
        chk("t5_beat0_wlast", s_if.wlast, 0);
        @(negedge clk);
        m0_if.wdata = 32'h9ABC_DEF0; m0_if.wlast = 1;
        #1;
        chk("t5_beat1_wready", m0_if.wready, 1);
        chk("t5_beat1_wlast", s_if.wlast, 1);
        @(negedge clk);
        m0_if.wvalid = 0; m0_if.wlast = 0; m0_if.bready = 1; s_if.bvalid = 1;
        #1;
        chk("t5_resp_wready", m0_if.wready, 0);
        chk("t5_m0_bvalid", m0_if.bvalid, 1);
        @(negedge clk);
        s_if.bvalid = 0; m0_if.bready = 0;
        #1;
        chk("t5_idle_awvalid", s_if.awvalid, 0);
        chk("t5_idle_bready", s_if.bready, 0);

        // Reset during beat 2 of a 4-beat read
        @(negedge clk);
        m0_if.araddr = 32'h9000; m0_if.arlen = 4'd3; m0_if.arvalid = 1; s_if.arready = 1;
        @(negedge clk);
        #1 chk("t6_araddr", s_if.araddr, 32'h9000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) m0_if.arvalid = 0;
            s_if.rvalid = 1; s_if.rdata = 32'hF000 + i; s_if.rlast = 0; m0_if.rready = 1;
            #1 chk("t6_m0_rvalid", m0_if.rvalid, 1);
        end
        #1 rst = 1;
        #1;
        chk("t6_rst_rready", s_if.rready, 0);
        chk("t6_rst_arvalid", s_if.arvalid, 0);
        chk("t6_rst_m0_rvalid", m0_if.rvalid, 0);
        chk("t6_rst_m0_rdata", m0_if.rdata, 0);
        @(negedge clk);
        rst = 0; s_if.rvalid = 0;
        m0_if.araddr = 32'hA100; m0_if.arlen = 4'd0; m0_if.arvalid = 1;
        m1_if.araddr = 32'hA200; m1_if.arlen = 4'd0; m1_if.arvalid = 1;
        #1 chk("t6_idle_arvalid", s_if.arvalid, 0);
        @(negedge clk); #1;
        chk("t6_tie_araddr", s_if.araddr, 32'hA100);
        chk("t6_tie_m0_arready", m0_if.arready, 1);
        chk("t6_tie_m1_arready", m1_if.arready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
